// File: rtl/rx_watchdog_rst_ctrl.sv
// rx_watchdog_rst_ctrl: qualifies RX watchdog events and issues a timed receiver
// reset. After the pulse it applies a holdoff window. Bursts of resets lead to a
// lockout that lasts until the power trigger drops. It also keeps the reset
// statistics and the last-cause capture that the register file reads.
module rx_watchdog_rst_ctrl #(
  parameter int NUM_EVENTS = 5,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  power_trigger,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [NUM_EVENTS-1:0] event_mask,
  input  logic [LEN_WIDTH-1:0]  rst_len,
  input  logic [LEN_WIDTH-1:0]  holdoff_len,
  input  logic [15:0]           quiet_len,
  input  logic [3:0]            max_rst_burst,
  input  logic                  stat_clr,
  output logic                  receiver_rst,
  output logic [1:0]            state_out,
  output logic [NUM_EVENTS-1:0] last_cause,
  output logic [2:0]            last_cause_id,
  output logic                  last_cause_valid,
  output logic [CNT_WIDTH-1:0]  rst_count,
  output logic [CNT_WIDTH-1:0]  lockout_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_HOLD = 2'd2,
    S_LOCK = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  receiver_rst_q, receiver_rst_d;
  logic [LEN_WIDTH-1:0]  len_cnt_q, len_cnt_d;
  logic [15:0]           quiet_cnt_q, quiet_cnt_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [NUM_EVENTS-1:0] last_cause_q, last_cause_d;
  logic [2:0]            last_cause_id_q, last_cause_id_d;
  logic                  last_cause_valid_q, last_cause_valid_d;
  logic [CNT_WIDTH-1:0]  rst_count_q, rst_count_d;
  logic [CNT_WIDTH-1:0]  lockout_count_q, lockout_count_d;

  logic [NUM_EVENTS-1:0] masked;
  logic                  qualified;
  logic [LEN_WIDTH-1:0]  rst_eff;
  logic [LEN_WIDTH:0]    len_nxt;
  logic                  rst_done, hold_done, burst_hit, quiet_hit;
  logic [16:0]           quiet_nxt;
  logic                  trigger, enter_lock;
  logic [2:0]            cause_id_c;

  assign masked    = event_in & event_mask;
  assign qualified = enable & power_trigger & (|masked);
  assign rst_eff   = (rst_len == '0) ? LEN_WIDTH'(1) : rst_len;
  // len_nxt counts the current cycle. A comparison with >= lets a length
  // lowered mid-window end the window at once.
  assign len_nxt   = {1'b0, len_cnt_q} + 1'b1;
  assign rst_done  = len_nxt >= {1'b0, rst_eff};
  assign hold_done = len_nxt >= {1'b0, holdoff_len};
  assign burst_hit = (max_rst_burst != 4'd0) && (burst_cnt_q >= max_rst_burst);
  assign quiet_nxt = {1'b0, quiet_cnt_q} + 1'b1;
  assign quiet_hit = (quiet_len != 16'd0) && (quiet_nxt >= {1'b0, quiet_len});
  assign trigger   = (state_q == S_IDLE) && qualified;

  // lowest set bit of the masked event vector
  always_comb begin
    cause_id_c = 3'd0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (masked[i]) cause_id_c = 3'(i);
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q            <= S_IDLE;
      receiver_rst_q     <= 1'b0;
      len_cnt_q          <= '0;
      quiet_cnt_q        <= '0;
      burst_cnt_q        <= '0;
      last_cause_q       <= '0;
      last_cause_id_q    <= '0;
      last_cause_valid_q <= 1'b0;
      rst_count_q        <= '0;
      lockout_count_q    <= '0;
    end else begin
      state_q            <= state_d;
      receiver_rst_q     <= receiver_rst_d;
      len_cnt_q          <= len_cnt_d;
      quiet_cnt_q        <= quiet_cnt_d;
      burst_cnt_q        <= burst_cnt_d;
      last_cause_q       <= last_cause_d;
      last_cause_id_q    <= last_cause_id_d;
      last_cause_valid_q <= last_cause_valid_d;
      rst_count_q        <= rst_count_d;
      lockout_count_q    <= lockout_count_d;
    end
  end

  // next-state logic; disable overrides everything
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (qualified) state_d = S_RST;
        S_RST: begin
          if (rst_done) begin
            if (burst_hit)                state_d = S_LOCK;
            else if (holdoff_len != '0)   state_d = S_HOLD;
            else                          state_d = S_IDLE;
          end
        end
        S_HOLD: if (hold_done)      state_d = S_IDLE;
        S_LOCK: if (!power_trigger) state_d = S_IDLE;
        default:                    state_d = S_IDLE;
      endcase
    end
  end

  // registered outputs: the reset line follows the next state
  always_comb begin
    receiver_rst_d = (state_d == S_RST);
  end

  // window, quiet and burst counters plus statistics
  always_comb begin
    len_cnt_d          = '0;
    quiet_cnt_d        = '0;
    burst_cnt_d        = burst_cnt_q;
    last_cause_d       = last_cause_q;
    last_cause_id_d    = last_cause_id_q;
    last_cause_valid_d = last_cause_valid_q;
    rst_count_d        = rst_count_q;
    lockout_count_d    = lockout_count_q;
    enter_lock         = enable && (state_q == S_RST) && (state_d == S_LOCK);

    // len_cnt runs only while staying in RST/HOLDOFF and restarts on any change
    if (enable && (state_d == state_q) &&
        ((state_q == S_RST) || (state_q == S_HOLD)))
      len_cnt_d = len_nxt[LEN_WIDTH-1:0];

    if (!enable) begin
      burst_cnt_d = '0;
    end else if (trigger) begin
      if (burst_cnt_q != 4'hF) burst_cnt_d = burst_cnt_q + 4'd1;
    end else if (state_q == S_IDLE) begin
      if (quiet_hit) begin
        burst_cnt_d = '0;
      end else if (quiet_cnt_q != 16'hFFFF) begin
        quiet_cnt_d = quiet_nxt[15:0];
      end else begin
        quiet_cnt_d = quiet_cnt_q;
      end
    end else if ((state_q == S_LOCK) && !power_trigger) begin
      burst_cnt_d = '0;
    end

    if (trigger) begin
      last_cause_d       = masked;
      last_cause_id_d    = cause_id_c;
      last_cause_valid_d = 1'b1;
      if (rst_count_q != '1) rst_count_d = rst_count_q + 1'b1;
    end
    if (enter_lock && (lockout_count_q != '1))
      lockout_count_d = lockout_count_q + 1'b1;

    // a clear takes priority over a capture or increment in the same cycle
    if (stat_clr) begin
      last_cause_d       = '0;
      last_cause_id_d    = '0;
      last_cause_valid_d = 1'b0;
      rst_count_d        = '0;
      lockout_count_d    = '0;
    end
  end

  assign receiver_rst     = receiver_rst_q;
  assign state_out        = state_q;
  assign last_cause       = last_cause_q;
  assign last_cause_id    = last_cause_id_q;
  assign last_cause_valid = last_cause_valid_q;
  assign rst_count        = rst_count_q;
  assign lockout_count    = lockout_count_q;

endmodule
